clct_busy_ctrl: RTL and testbench
=================================

Name: clct_busy_ctrl

Overview:
- Sequential stage directly downstream of the best-1-of-5 CFEB sorter.
- Registers the sorter's winning CLCT (pattern, key, carry) and applies a hit threshold.
- Hands the result to the CLCT output logic with a valid/ready handshake.
- Generates per-CFEB dead-time busy flags that feed back into the sorter's bsy0..bsy4 inputs.

Parameters:
- MXPATB, 6, pattern bits; [5:3] = hit count, [2:0] = pattern id.
- MXKEYBX, 8, 1/2-strip key bits; [7:5] = CFEB index, [4:0] = key within CFEB.
- MXPATC, 11, carry (comparator code) bits.
- MXCFEB, 5, number of CFEBs.
- MXDTB, 4, dead-time counter width.

Ports:
- clock  in  1  main clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- best_pat  in  MXPATB  sorter winning pattern.
- best_key  in  MXKEYBX  sorter winning key.
- best_carry  in  MXPATC  sorter winning carry.
- best_bsy  in  1  sorter reports no eligible candidate.
- hit_thresh  in  3  minimum best_pat[5:3] to accept.
- dead_time  in  MXDTB  busy hold, in clocks; 0 disables busy.
- clct_rdy  in  1  downstream ready.
- clct_vld  out  1  output register holds a CLCT.
- clct_pat  out  MXPATB  registered pattern.
- clct_key  out  MXKEYBX  registered key.
- clct_carry  out  MXPATC  registered carry.
- bsy  out  MXCFEB  per-CFEB busy; bit c drives sorter bsy<c>.
- drop_cnt  out  8  saturating count of qualified CLCTs lost to backpressure.

Behaviour:
Reset:
- Asynchronous assert of reset_n clears clct_vld, clct_pat, clct_key, clct_carry, bsy, drop_cnt and all dead-time counters.
- Mid-operation reset discards any held CLCT.
- First accept is possible on the first edge after deassertion.

Definitions:
- cfeb = best_key[7:5]; kin = best_key[4:0].
- qual = !best_bsy && best_pat[5:3] >= hit_thresh && cfeb < MXCFEB && !bsy[cfeb].
- room = !clct_vld || clct_rdy.
- accept = qual && room.

Output register (latency 1 clock):
- On accept, load clct_pat/key/carry from the inputs and set clct_vld = 1.
- Else if clct_vld && clct_rdy, clear clct_vld; data fields hold their last value.
- Else hold.
- While clct_vld && !clct_rdy, outputs are stable.
- Transfer occurs on any clock with clct_vld && clct_rdy. Accept and transfer may happen on the same edge (back-to-back throughput of 1 per clock).

Drop counter:
- Increments when qual && !room; saturates at 255.
- Unqualified candidates are never counted.

Dead-time counters (one per CFEB, cnt[c]):
- bsy[c] = (cnt[c] != 0), registered.
- On accept with dead_time != 0: cnt[cfeb] loads dead_time. A load overrides a decrement in the same clock.
- Otherwise, each clock cnt[c] decrements if nonzero.
- The busy bit therefore rises the clock after accept and stays high exactly dead_time clocks.
- dead_time = 0: no counter loads, bsy stays 0.
- A dead_time change takes effect on the next load only.

Boundary conditions:
- Because qual requires !bsy[cfeb], a busy CFEB can never be re-accepted, even if the sorter presents it.
- best_key with cfeb > 4 is ignored: no accept, no drop count.

Optional Feature:
BSY_NEIGHBOR_EN:
- Defined: an accept also loads the neighbour counter.
  - kin <= 1 and cfeb > 0: load cnt[cfeb-1].
  - kin >= 30 and cfeb < MXCFEB-1: load cnt[cfeb+1].
  - Edge CFEBs (0 and MXCFEB-1) never wrap.
- Undefined: only cnt[cfeb] is loaded.

Test Plan:
- Reset release, hit_thresh=4, dead_time=3, clct_rdy=1; best_pat=6'b101_010, key=8'h45, best_bsy=0 for one clock -> next clock clct_vld=1, clct_key=8'h45; bsy=5'b00100 for exactly 3 clocks; drop_cnt=0.
- best_pat hits=3 with hit_thresh=4, or best_bsy=1 -> clct_vld stays 0, bsy stays 0, drop_cnt stays 0.
- clct_rdy=0, two qualified CLCTs on consecutive clocks (CFEB1 then CFEB3) -> first held stable with clct_vld=1; drop_cnt=1; bsy[3] never set. Raising clct_rdy clears clct_vld the next clock.
- Re-present CFEB2 during its busy window -> rejected. After bsy[2] falls -> re-accepted and counter reloaded to dead_time; dead_time=0 -> bsy never asserts.
- With BSY_NEIGHBOR_EN: key=8'h41 (kin=1) -> bsy=5'b00110; key=8'h9F (kin=31, CFEB4) -> bsy=5'b10000 only. Without the macro, key=8'h41 -> bsy=5'b00100.
- 300 dropped CLCTs under clct_rdy=0 -> drop_cnt saturates at 255. Assert reset_n low mid-hold -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/clct_busy_ctrl_if.sv
// Sorter-to-CLCT-output bus for clct_busy_ctrl: winning candidate, threshold/dead-time config,
// registered CLCT handshake, per-CFEB busy feedback and drop counter.
interface clct_busy_ctrl_if #(
   parameter int unsigned MXPATB  = 6,
   parameter int unsigned MXKEYBX = 8,
   parameter int unsigned MXPATC  = 11,
   parameter int unsigned MXCFEB  = 5,
   parameter int unsigned MXDTB   = 4
);
   logic [MXPATB-1:0]  best_pat;
   logic [MXKEYBX-1:0] best_key;
   logic [MXPATC-1:0]  best_carry;
   logic               best_bsy;
   logic [2:0]         hit_thresh;
   logic [MXDTB-1:0]   dead_time;
   logic               clct_rdy;
   logic               clct_vld;
   logic [MXPATB-1:0]  clct_pat;
   logic [MXKEYBX-1:0] clct_key;
   logic [MXPATC-1:0]  clct_carry;
   logic [MXCFEB-1:0]  bsy;
   logic [7:0]         drop_cnt;

   modport master (
      output best_pat, best_key, best_carry, best_bsy, hit_thresh, dead_time, clct_rdy,
      input  clct_vld, clct_pat, clct_key, clct_carry, bsy, drop_cnt
   );

   modport slave (
      input  best_pat, best_key, best_carry, best_bsy, hit_thresh, dead_time, clct_rdy,
      output clct_vld, clct_pat, clct_key, clct_carry, bsy, drop_cnt
   );
endinterface

// File: rtl/clct_busy_ctrl.sv
// Registers the best-of-5 CLCT behind a hit threshold, hands it off with valid/ready and
// generates per-CFEB dead-time busy flags. Define BSY_NEIGHBOR_EN to also busy edge neighbours.
module clct_busy_ctrl #(
   parameter int unsigned MXPATB  = 6,
   parameter int unsigned MXKEYBX = 8,
   parameter int unsigned MXPATC  = 11,
   parameter int unsigned MXCFEB  = 5,
   parameter int unsigned MXDTB   = 4
) (
   input logic             clock,
   input logic             reset_n,
   clct_busy_ctrl_if.slave io_bus
);
   localparam int unsigned CfebW = MXKEYBX - 5;

   logic [CfebW-1:0]  w_cfeb;
   logic [MXCFEB-1:0] w_sel;
   logic [MXCFEB-1:0] w_load;
   logic [MXCFEB-1:0] w_bsy_d;
   logic [MXDTB-1:0]  w_cnt_d [MXCFEB];
   logic              w_qual;
   logic              w_room;
   logic              w_accept;
   logic              w_dt_en;
`ifdef BSY_NEIGHBOR_EN
   logic [4:0]        w_kin;
`endif

   logic                r_vld;
   logic [MXPATB-1:0]   r_pat;
   logic [MXKEYBX-1:0]  r_key;
   logic [MXPATC-1:0]   r_carry;
   logic [MXCFEB-1:0]   r_bsy;
   logic [7:0]          r_drop;
   logic [MXDTB-1:0]    r_cnt [MXCFEB];

   always_comb begin
      w_cfeb = io_bus.best_key[MXKEYBX-1 -: CfebW];
      // One-hot CFEB select; an out-of-range index selects nothing and so never qualifies
      for (int c = 0; c < int'(MXCFEB); c++) begin
         w_sel[c] = (int'(w_cfeb) == c);
      end
      w_qual   = !io_bus.best_bsy
               && (io_bus.best_pat[MXPATB-1 -: 3] >= io_bus.hit_thresh)
               && (|w_sel)
               && !(|(w_sel & r_bsy));
      w_room   = !r_vld || io_bus.clct_rdy;
      w_accept = w_qual && w_room;
      w_dt_en  = w_accept && (io_bus.dead_time != '0);
   end

   always_comb begin
      w_load = w_sel;
`ifdef BSY_NEIGHBOR_EN
      w_kin = io_bus.best_key[4:0];
      for (int c = 0; c < int'(MXCFEB) - 1; c++) begin
         if (w_sel[c+1] && (w_kin <= 5'd1)) w_load[c] = 1'b1;
         if (w_sel[c] && (w_kin >= 5'd30)) w_load[c+1] = 1'b1;
      end
`endif
      if (!w_dt_en) w_load = '0;
      for (int c = 0; c < int'(MXCFEB); c++) begin
         if (w_load[c]) begin
            w_cnt_d[c] = io_bus.dead_time;
         end else if (r_cnt[c] != '0) begin
            w_cnt_d[c] = r_cnt[c] - MXDTB'(1);
         end else begin
            w_cnt_d[c] = r_cnt[c];
         end
         w_bsy_d[c] = (w_cnt_d[c] != '0);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vld   <= 1'b0;
         r_pat   <= '0;
         r_key   <= '0;
         r_carry <= '0;
         r_bsy   <= '0;
         r_drop  <= '0;
         for (int c = 0; c < int'(MXCFEB); c++) r_cnt[c] <= '0;
      end else begin
         if (w_accept) begin
            r_vld   <= 1'b1;
            r_pat   <= io_bus.best_pat;
            r_key   <= io_bus.best_key;
            r_carry <= io_bus.best_carry;
         end else if (r_vld && io_bus.clct_rdy) begin
            r_vld <= 1'b0;
         end
         if (w_qual && !w_room && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
         for (int c = 0; c < int'(MXCFEB); c++) r_cnt[c] <= w_cnt_d[c];
         r_bsy <= w_bsy_d;
      end
   end

   assign io_bus.clct_vld   = r_vld;
   assign io_bus.clct_pat   = r_pat;
   assign io_bus.clct_key   = r_key;
   assign io_bus.clct_carry = r_carry;
   assign io_bus.bsy        = r_bsy;
   assign io_bus.drop_cnt   = r_drop;
endmodule

// File: tb/tb_clct_busy_ctrl.sv
// Directed bench for clct_busy_ctrl: expected transfers go to a queue checked by a monitor,
// busy/drop/valid levels are compared against hand-computed constants.
module tb_clct_busy_ctrl;
   logic clock;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   logic [24:0] exp_q [$];

`ifdef BSY_NEIGHBOR_EN
   localparam logic [4:0] ExpBsy41 = 5'b00110;
`else
   localparam logic [4:0] ExpBsy41 = 5'b00100;
`endif

   clct_busy_ctrl_if u_if ();

   clct_busy_ctrl u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .io_bus  (u_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Monitor: every edge with vld && rdy is a transfer; sample half a cycle before it
   always @(negedge clock) begin
      if (reset_n && u_if.clct_vld && u_if.clct_rdy) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL xfer_unexpected: got %h expected none",
                     {u_if.clct_pat, u_if.clct_key, u_if.clct_carry});
         end else begin
            logic [24:0] e;
            e = exp_q.pop_front();
            if ({u_if.clct_pat, u_if.clct_key, u_if.clct_carry} !== e) begin
               n_fail++;
               $display("FAIL xfer_data: got %h expected %h",
                        {u_if.clct_pat, u_if.clct_key, u_if.clct_carry}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic present(input logic [5:0] pat, input logic [7:0] key, input logic [10:0] carry,
                          input bit exp_acc);
      u_if.best_pat   = pat;
      u_if.best_key   = key;
      u_if.best_carry = carry;
      u_if.best_bsy   = 1'b0;
      if (exp_acc) exp_q.push_back({pat, key, carry});
   endtask

   task automatic idle();
      u_if.best_bsy = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      u_if.best_pat   = '0;
      u_if.best_key   = '0;
      u_if.best_carry = '0;
      u_if.best_bsy   = 1'b1;
      u_if.hit_thresh = 3'd4;
      u_if.dead_time  = 4'd3;
      u_if.clct_rdy   = 1'b1;
      repeat (2) tick();
      check("rst_vld", {31'd0, u_if.clct_vld}, 32'd0);
      check("rst_bsy", {27'd0, u_if.bsy}, 32'd0);
      check("rst_drop", {24'd0, u_if.drop_cnt}, 32'd0);
      reset_n = 1'b1;

      // Basic accept on CFEB2, busy for exactly 3 clocks
      present(6'b101_010, 8'h45, 11'h123, 1'b1);
      tick();
      idle();
      check("t1_vld", {31'd0, u_if.clct_vld}, 32'd1);
      check("t1_key", {24'd0, u_if.clct_key}, 32'h45);
      check("t1_bsy0", {27'd0, u_if.bsy}, 32'b00100);
      tick();
      check("t1_bsy1", {27'd0, u_if.bsy}, 32'b00100);
      check("t1_vld_clr", {31'd0, u_if.clct_vld}, 32'd0);
      tick();
      check("t1_bsy2", {27'd0, u_if.bsy}, 32'b00100);
      tick();
      check("t1_bsy3", {27'd0, u_if.bsy}, 32'b00000);
      check("t1_drop", {24'd0, u_if.drop_cnt}, 32'd0);

      // Below threshold, then sorter-busy
      present(6'b011_001, 8'h45, 11'h001, 1'b0);
      tick();
      check("t2_lowhit_vld", {31'd0, u_if.clct_vld}, 32'd0);
      check("t2_lowhit_bsy", {27'd0, u_if.bsy}, 32'd0);
      present(6'b111_001, 8'h45, 11'h002, 1'b0);
      u_if.best_bsy = 1'b1;
      tick();
      check("t2_sbsy_vld", {31'd0, u_if.clct_vld}, 32'd0);
      check("t2_sbsy_bsy", {27'd0, u_if.bsy}, 32'd0);
      check("t2_drop", {24'd0, u_if.drop_cnt}, 32'd0);

      // Backpressure: CFEB1 held, CFEB3 dropped
      u_if.clct_rdy = 1'b0;
      present(6'b110_011, 8'h2A, 11'h2AA, 1'b1);
      tick();
      present(6'b111_000, 8'h63, 11'h333, 1'b0);
      tick();
      check("t3_drop1", {24'd0, u_if.drop_cnt}, 32'd1);
      check("t3_hold_vld", {31'd0, u_if.clct_vld}, 32'd1);
      check("t3_hold_key", {24'd0, u_if.clct_key}, 32'h2A);
      check("t3_bsy", {27'd0, u_if.bsy}, 32'b00010);
      present(6'b111_000, 8'hA0, 11'h444, 1'b0);
      tick();
      check("t3_cfeb5_drop", {24'd0, u_if.drop_cnt}, 32'd1);
      present(6'b111_000, 8'h2A, 11'h555, 1'b0);
      tick();
      check("t3_busy_drop", {24'd0, u_if.drop_cnt}, 32'd1);
      check("t3_hold_pat", {26'd0, u_if.clct_pat}, 32'b110_011);
      idle();
      u_if.clct_rdy = 1'b1;
      tick();
      check("t3_release_vld", {31'd0, u_if.clct_vld}, 32'd0);

      // CFEB2 re-presented during its busy window
      present(6'b101_010, 8'h45, 11'h0AA, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_reject_vld", {31'd0, u_if.clct_vld}, 32'd0);
      end
      check("t4_bsy_fell", {27'd0, u_if.bsy}, 32'd0);
      present(6'b101_010, 8'h45, 11'h155, 1'b1);
      tick();
      check("t4_reacc_vld", {31'd0, u_if.clct_vld}, 32'd1);
      check("t4_reacc_bsy", {27'd0, u_if.bsy}, 32'b00100);
      idle();
      u_if.dead_time = 4'd0;
      tick();
      check("t4_dt_late", {27'd0, u_if.bsy}, 32'b00100);
      repeat (2) tick();
      check("t4_dt_clear", {27'd0, u_if.bsy}, 32'd0);
      present(6'b101_000, 8'h21, 11'h7FF, 1'b1);
      tick();
      idle();
      check("t4_dt0_vld", {31'd0, u_if.clct_vld}, 32'd1);
      check("t4_dt0_bsy", {27'd0, u_if.bsy}, 32'd0);
      tick();
      check("t4_dt0_bsy2", {27'd0, u_if.bsy}, 32'd0);

      // Neighbour busy; hits equal to threshold must be accepted
      u_if.dead_time = 4'd3;
      present(6'b100_111, 8'h41, 11'h041, 1'b1);
      tick();
      idle();
      check("t5_bsy41", {27'd0, u_if.bsy}, {27'd0, ExpBsy41});
      repeat (3) tick();
      check("t5_bsy41_clr", {27'd0, u_if.bsy}, 32'd0);
      present(6'b100_111, 8'h9F, 11'h09F, 1'b1);
      tick();
      idle();
      check("t5_bsy9f", {27'd0, u_if.bsy}, 32'b10000);
      repeat (3) tick();

      // Drop counter saturation
      u_if.clct_rdy = 1'b0;
      present(6'b110_000, 8'h85, 11'h085, 1'b1);
      tick();
      present(6'b110_000, 8'h05, 11'h005, 1'b0);
      repeat (300) tick();
      idle();
      check("t6_drop_sat", {24'd0, u_if.drop_cnt}, 32'd255);
      check("t6_hold_key", {24'd0, u_if.clct_key}, 32'h85);
      check("t6_hold_vld", {31'd0, u_if.clct_vld}, 32'd1);

      // Asynchronous reset mid-hold
      #2;
      reset_n = 1'b0;
      #1;
      check("t7_rst_vld", {31'd0, u_if.clct_vld}, 32'd0);
      check("t7_rst_key", {24'd0, u_if.clct_key}, 32'd0);
      check("t7_rst_pat", {26'd0, u_if.clct_pat}, 32'd0);
      check("t7_rst_carry", {21'd0, u_if.clct_carry}, 32'd0);
      check("t7_rst_bsy", {27'd0, u_if.bsy}, 32'd0);
      check("t7_rst_drop", {24'd0, u_if.drop_cnt}, 32'd0);
      exp_q.delete();
      #2;
      reset_n = 1'b1;
      u_if.clct_rdy = 1'b1;
      present(6'b101_010, 8'h45, 11'h321, 1'b1);
      tick();
      idle();
      check("t7_first_vld", {31'd0, u_if.clct_vld}, 32'd1);
      check("t7_first_bsy", {27'd0, u_if.bsy}, 32'b00100);
      repeat (4) tick();
      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
